// File: rtl/mult_pkg.sv
// Shared definitions for the sequential HI/LO multiplier.
package mult_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned MULT_STEPS = 32;
   localparam int unsigned CNT_W      = $clog2(MULT_STEPS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FIXUP = 2'd2
   } state_t;

endpackage

// File: rtl/twos_neg.sv
// Combinational two's-complement negation of a W-bit value.
module twos_neg #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] value,
   output logic [W-1:0] neg
);

   always_comb begin
      neg = (~value) + W'(1);
   end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential 32x32 multiplier with MIPS-style HI/LO registers,
// MULT/MULTU support, restart-on-start and MTHI/MTLO writes.
module seq_multiplier
   import mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [DATA_W-1:0] wdata,
   output logic              pve,
   output logic              busy,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   state_t                state;
   logic [CNT_W-1:0]      count;
   logic [2*DATA_W-1:0]   acc;
   logic [2*DATA_W-1:0]   mcand;
   logic [DATA_W-1:0]     mplier;
   logic                  neg_res;

   logic [DATA_W-1:0]     a_neg;
   logic [DATA_W-1:0]     b_neg;
   logic [2*DATA_W-1:0]   acc_neg;
   logic [DATA_W-1:0]     a_mag;
   logic [DATA_W-1:0]     b_mag;
   logic [2*DATA_W-1:0]   product;

   twos_neg #(.W(DATA_W))   u_neg_a (.value(a),   .neg(a_neg));
   twos_neg #(.W(DATA_W))   u_neg_b (.value(b),   .neg(b_neg));
   twos_neg #(.W(2*DATA_W)) u_neg_p (.value(acc), .neg(acc_neg));

   // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
   always_comb begin
      a_mag   = (is_signed && a[DATA_W-1]) ? a_neg : a;
      b_mag   = (is_signed && b[DATA_W-1]) ? b_neg : b;
      product = neg_res ? acc_neg : acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         neg_res <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pve     <= 1'b1;
         busy    <= 1'b0;
      end else if (start) begin
         // Start wins in every state; a pending operation is simply dropped.
         state   <= BUSY;
         count   <= CNT_W'(MULT_STEPS);
         acc     <= '0;
         mcand   <= {{DATA_W{1'b0}}, a_mag};
         mplier  <= b_mag;
         neg_res <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
         pve     <= 1'b0;
         busy    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
            end
            BUSY: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - CNT_W'(1);
               if (count == CNT_W'(1)) state <= FIXUP;
            end
            FIXUP: begin
               hi    <= product[2*DATA_W-1:DATA_W];
               lo    <= product[DATA_W-1:0];
               state <= IDLE;
               pve   <= 1'b1;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               pve   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier.
module tb_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        pve;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks;
   int n_fail;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   seq_multiplier dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .wdata     (wdata),
      .pve       (pve),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
      end
   endtask

   // Drive start at a falling edge; returns in cycle 1 (first negedge after the sampling edge).
   task automatic start_op(input logic [31:0] aa, input logic [31:0] bb, input logic sg);
      @(negedge clk);
      start = 1'b1; a = aa; b = bb; is_signed = sg;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Checks cycles from..to as pending with hi/lo held; returns in cycle to+1.
   task automatic pend_check(input int from, input int to, input string tag);
      for (int k = from; k <= to; k++) begin
         check({tag, "_pve"},  {63'd0, pve},  64'd0);
         check({tag, "_busy"}, {63'd0, busy}, 64'd1);
         check({tag, "_hi"},   {32'd0, hi},   {32'd0, exp_hi});
         check({tag, "_lo"},   {32'd0, lo},   {32'd0, exp_lo});
         @(negedge clk);
      end
   endtask

   task automatic done_check(input string tag, input logic [31:0] h, input logic [31:0] l);
      check({tag, "_pve_done"},  {63'd0, pve},  64'd1);
      check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
      check({tag, "_hi"},        {32'd0, hi},   {32'd0, h});
      check({tag, "_lo"},        {32'd0, lo},   {32'd0, l});
      exp_hi = h;
      exp_lo = l;
   endtask

   task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                         input logic sg, input logic [31:0] h, input logic [31:0] l);
      start_op(aa, bb, sg);
      pend_check(1, 33, tag);
      done_check(tag, h, l);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
      a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      exp_hi = '0; exp_lo = '0;

      repeat (2) @(negedge clk);
      check("rst_pve",  {63'd0, pve},  64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hi",   {32'd0, hi},   64'd0);
      check("rst_lo",   {32'd0, lo},   64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_pve", {63'd0, pve}, 64'd1);

      run_op("multu_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_m3x7",   32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("mult_min2",   32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
      run_op("mult_minx1",  32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000);
      run_op("multu_minx2", 32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000);
      run_op("multu_fdx7",  32'hFFFFFFFD, 32'h00000007, 1'b0, 32'h00000006, 32'hFFFFFFEB);

      // Restart: 5*5 at cycle 0 is abandoned by 2*3 at cycle 10.
      start_op(32'd5, 32'd5, 1'b1);
      pend_check(1, 9, "restart");
      check("restart_c10_pve", {63'd0, pve}, 64'd0);
      check("restart_c10_lo",  {32'd0, lo},  {32'd0, exp_lo});
      start = 1'b1; a = 32'd2; b = 32'd3; is_signed = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pend_check(11, 43, "restart");
      done_check("restart", 32'd0, 32'd6);

      // MTHI ignored while busy, then accepted in IDLE.
      start_op(32'h00010000, 32'h00030000, 1'b0);
      pend_check(1, 4, "mthi_busy");
      hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      pend_check(6, 33, "mthi_busy");
      done_check("mthi_busy", 32'h00000003, 32'h00000000);

      hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi_hi", {32'd0, hi}, 64'h1234);
      check("mthi_lo", {32'd0, lo}, 64'h0);

      lo_we = 1'b1; wdata = 32'hABCD;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo_lo", {32'd0, lo}, 64'hABCD);
      check("mtlo_hi", {32'd0, hi}, 64'h1234);

      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mtboth_hi", {32'd0, hi}, 64'h5555);
      check("mtboth_lo", {32'd0, lo}, 64'h5555);
      exp_hi = 32'h5555; exp_lo = 32'h5555;

      // Start has priority over simultaneous MTHI/MTLO.
      start = 1'b1; a = 32'd2; b = 32'd3; is_signed = 1'b0;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      pend_check(1, 33, "start_prio");
      done_check("start_prio", 32'd0, 32'd6);

      // Mid-operation reset at cycle 20.
      start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      pend_check(1, 19, "midrst");
      #2 rst_n = 1'b0;
      #1;
      check("midrst_pve",  {63'd0, pve},  64'd1);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_hi",   {32'd0, hi},   64'd0);
      check("midrst_lo",   {32'd0, lo},   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         check("postrst_pve", {63'd0, pve},     64'd1);
         check("postrst_hilo", {hi, lo},        64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  in  1  begin multiply; single-cycle pulse from execute stage (multstartE).
REQ-004 SHALL have port is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-005 SHALL have port a  in  32  multiplicand, sampled with start.
REQ-006 SHALL have port b  in  32  multiplier, sampled with start.
REQ-007 SHALL have port hi_we  in  1  MTHI write strobe.
REQ-008 SHALL have port lo_we  in  1  MTLO write strobe.
REQ-009 SHALL have port wdata  in  32  MTHI/MTLO data.
REQ-010 SHALL have port pve  out  1  product valid; 0 while an operation is pending, 1 otherwise; drives hazard unit.
REQ-011 SHALL have port busy  out  1  1 in BUSY or FIXUP.
REQ-012 SHALL have port hi  out  32  registered HI.
REQ-013 SHALL have port lo  out  32  registered LO.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, FIXUP.
REQ-015 SHALL, in IDLE with start=1, latch |a|, |b| (magnitudes if is_signed, raw otherwise), result sign = a[31]^b[31] (signed only), clear 64-bit accumulator, load count=32, go to BUSY.
REQ-016 SHALL, in BUSY, perform one radix-2 shift-add step per cycle (add multiplicand if current multiplier LSB=1, shift), decrement count, go to FIXUP after the 32nd step.
REQ-017 SHALL, in FIXUP, write hi:lo = accumulator, negated (64-bit two's complement) if result sign=1, then go to IDLE.
REQ-018 SHALL, with start sampled high at the end of cycle 0, drive pve=0 in cycles 1..33 and pve=1 with valid hi/lo from cycle 34 (fixed 33-cycle latency, independent of operands).
REQ-019 SHALL, on start in BUSY or FIXUP, abort the current operation without updating hi/lo and restart per REQ-015; pve remains 0.
REQ-020 SHALL hold hi/lo unchanged from FIXUP until the next FIXUP, MTHI/MTLO write, or reset.
REQ-021 SHALL, in IDLE with start=0, write wdata to hi on hi_we and to lo on lo_we on that edge; both strobes together write both.
REQ-022 SHALL ignore hi_we/lo_we in BUSY/FIXUP and when start=1 in the same cycle (start has priority).
REQ-023 SHALL treat 0x80000000 magnitude as unsigned 2^31 (no overflow in abs).
REQ-024 SHALL keep pve=1 and busy=0 throughout IDLE.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force state=IDLE, count=0, accumulator=0, hi=0, lo=0, pve=1, busy=0, including mid-operation (operation discarded).
REQ-026 SHALL leave reset state on the first rising clk edge after rst_n deasserts.

Structure
REQ-027 SHALL place the state enum, MULT_STEPS=32 and DATA_W=32 in shared package mult_pkg.
REQ-028 SHALL use one combinational sub-module, twos_neg (parameterised width), for operand magnitude and 64-bit product negation.

Verification
REQ-029 SHALL cover: rst_n pulse at cycle 20 of an operation -> pve=1, busy=0, hi=lo=0 immediately; no later update.
REQ-030 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> pve=0 cycles 1..33; cycle 34 hi=0xFFFFFFFE, lo=0x00000001, pve=1.
REQ-031 SHALL cover: MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB at cycle 34.
REQ-032 SHALL cover: MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 SHALL cover: start (5*5) at cycle 0, start (2*3) at cycle 10 -> pve=0 cycles 1..43; cycle 44 lo=6, hi=0; 25 never appears.
REQ-034 SHALL cover: hi_we with wdata=0x1234 during BUSY -> hi unchanged; same write in IDLE -> hi=0x00001234 next cycle.
